overture_sequencer: RTL and testbench
=====================================

# overture_sequencer

Instruction sequencer and register-file controller for the 8-bit program ROM. Drives the ROM address as a program counter, decodes each returned byte (immediate, ALU, copy, conditional jump), and executes against six general registers. Register 6 is the I/O port, exposed through valid/ready handshakes. This turns the static program image into a running core on the board.

## Interface
Parameters:
- RESET_PC, 8'h00, program counter value after reset and on every IDLE→EXEC start.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- rom_addr  output  8  ROM address; equals PC
- rom_data  input  8  ROM dataout; combinational from rom_addr
- run  input  1  level; 1 = execute, 0 = stop at next instruction boundary
- busy  output  1  1 when state ≠ IDLE
- out_data  output  8  output port byte, registered
- out_valid  output  1  output byte pending
- out_ready  input  1  consumer accepts out_data
- in_data  input  8  input port byte
- in_valid  input  1  producer offers in_data
- in_ready  output  1  sequencer consumes in_data this cycle, combinational

## Operation
- States: IDLE, EXEC, OUT_WAIT.
  - IDLE: PC held at RESET_PC. run=1 moves to EXEC next edge.
  - EXEC: one instruction per cycle from rom_data.
  - OUT_WAIT: PC frozen until the output handshake completes.
- Registers r0–r5 are 8 bits each, reset to 0. Register index 6 is the I/O port. Index 7 reads 0; writes to it are discarded.
- Decode of rom_data[7:6]:
  - 00 IMM: r0 ← {2'b00, rom_data[5:0]}; PC+1.
  - 01 ALU: r3 ← f(r1, r2); PC+1. rom_data[2:0] selects: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (r1−r2). 6 and 7 write r3 ← 0. ADD and SUB are modulo 256; no flags.
  - 10 COPY: src = rom_data[5:3], dst = rom_data[2:0].
    - src≠6, dst≠6: dst ← src; PC+1.
    - dst=6: out_data ← value, out_valid ← 1, go to OUT_WAIT; PC not incremented.
    - src=6: in_ready=1 this cycle. If in_valid=0, stall (PC, regs and state unchanged). If in_valid=1, value = in_data, then perform the dst action above.
  - 11 JUMP: condition rom_data[2:0] evaluated on r3 as signed: 0 never, 1 =0, 2 <0, 3 ≤0, 4 always, 5 ≠0, 6 ≥0, 7 >0. True → PC ← r0; false → PC+1. rom_data[5:3] ignored.
- OUT_WAIT: on out_valid & out_ready, out_valid ← 0 and PC+1. Next state is EXEC if run=1, else IDLE.
- run=0 in EXEC: the instruction in this cycle completes (unless it stalls on input), then go to IDLE with PC ← RESET_PC. A stalled input read with run=0 aborts to IDLE with no state change.
- PC increments modulo 256: 8'hFF+1 = 8'h00.
- in_ready is 0 outside EXEC and whenever the current instruction does not read src 6.

## Timing
- Reset values: PC = RESET_PC, rom_addr = RESET_PC, state IDLE, busy 0, out_data 8'h00, out_valid 0, in_ready 0, r0–r5 = 0.
- Reset asserted mid-operation clears all of the above immediately. A pending output byte is dropped.
- Non-stalling instructions: 1 cycle each. rom_addr is registered, so the new PC is visible the cycle after execute.
- Output transfer: out_valid rises the edge after the COPY executes. It holds with stable out_data until the out_ready edge. Minimum cost is 2 cycles (COPY + 1 OUT_WAIT cycle).
- Input: consumed on the same edge as in_valid & in_ready. No buffering.
- Jump to PC itself (r0 = PC, always) loops indefinitely; this is legal and is not detected.

## Test plan
- Counting program, out_ready=1, run=1 from reset:
  - out_data sequence 0x30,0x31,…,0x39, then repeating.
  - First out_valid exactly 4 cycles after run asserts (IDLE→EXEC, pc0 IMM, pc1 IMM, pc2 COPY).
  - Each subsequent byte every 3 cycles.
  - Jump at 0x16 returns PC to 0x00.
- Backpressure: out_ready=0 for 10 cycles at the first byte → out_valid held, out_data=0x30 stable, rom_addr=0x02 frozen; release → next byte 0x31 follows normally.
- ALU:
  - r1=0xF0, r2=0x20: ADD → r3=0x10; SUB → r3=0xD0; NAND → r3=0xDF.
  - JUMP cond 2 (<0) taken on 0xD0; not taken on 0x10.
- Input path: COPY src6→dst6 with in_valid=0 for 5 cycles → in_ready=1, PC frozen; in_valid=1 with in_data=0xA5 → out_data=0xA5, out_valid next edge.
- Reset in OUT_WAIT: reset_n low while out_valid=1 → out_valid, busy, PC and regs cleared asynchronously; restart reproduces the first-byte timing.
- run=0 during execution → current instruction completes, busy falls next edge, rom_addr=RESET_PC; PC wrap from 0xFF to 0x00 verified with a NOP-filled image.

Source files
------------

// File: rtl/overture_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | overture_sequencer                                                   |
// | 8-bit ROM instruction sequencer with six registers and an I/O port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module overture_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       run,
  output logic       busy,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    OUT_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_IMM  = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_COPY = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;
  localparam logic [2:0] IO_IDX  = 3'd6;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] regs [6];

  logic [1:0] opc;
  logic [2:0] src;
  logic [2:0] dst;
  logic [7:0] src_val;
  logic [7:0] alu_val;
  logic       jump_taken;
  logic       stall;
  logic       to_out;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [7:0] wr_val;
  logic [7:0] pc_next;
  logic       r3_zero;
  logic       r3_neg;

  assign opc      = rom_data[7:6];
  assign src      = rom_data[5:3];
  assign dst      = rom_data[2:0];
  assign rom_addr = pc;
  assign busy     = (state != IDLE);
  assign in_ready = (state == EXEC) && (opc == OP_COPY) && (src == IO_IDX);
  assign stall    = in_ready && !in_valid;
  assign to_out   = (opc == OP_COPY) && (dst == IO_IDX);
  assign r3_zero  = (regs[3] == 8'h00);
  assign r3_neg   = regs[3][7];

  always_comb begin
    src_val = 8'h00;
    case (src)
      3'd0: src_val = regs[0];
      3'd1: src_val = regs[1];
      3'd2: src_val = regs[2];
      3'd3: src_val = regs[3];
      3'd4: src_val = regs[4];
      3'd5: src_val = regs[5];
      3'd6: src_val = in_data;
      default: src_val = 8'h00;
    endcase
  end

  always_comb begin
    alu_val = 8'h00;
    case (rom_data[2:0])
      3'd0: alu_val = regs[1] | regs[2];
      3'd1: alu_val = ~(regs[1] & regs[2]);
      3'd2: alu_val = ~(regs[1] | regs[2]);
      3'd3: alu_val = regs[1] & regs[2];
      3'd4: alu_val = regs[1] + regs[2];
      3'd5: alu_val = regs[1] - regs[2];
      default: alu_val = 8'h00;
    endcase
  end

  always_comb begin
    jump_taken = 1'b0;
    case (rom_data[2:0])
      3'd0: jump_taken = 1'b0;
      3'd1: jump_taken = r3_zero;
      3'd2: jump_taken = r3_neg;
      3'd3: jump_taken = r3_neg || r3_zero;
      3'd4: jump_taken = 1'b1;
      3'd5: jump_taken = !r3_zero;
      3'd6: jump_taken = !r3_neg;
      default: jump_taken = !r3_neg && !r3_zero;
    endcase
  end

  // Single register write port shared by IMM (r0), ALU (r3) and COPY (dst).
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = 3'd0;
    wr_val  = 8'h00;
    pc_next = pc + 8'd1;
    case (opc)
      OP_IMM: begin
        wr_en  = 1'b1;
        wr_idx = 3'd0;
        wr_val = {2'b00, rom_data[5:0]};
      end
      OP_ALU: begin
        wr_en  = 1'b1;
        wr_idx = 3'd3;
        wr_val = alu_val;
      end
      OP_COPY: begin
        wr_en  = !to_out;
        wr_idx = dst;
        wr_val = src_val;
      end
      default: begin
        if (jump_taken) pc_next = regs[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      for (int i = 0; i < 6; i++) regs[i] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          pc <= RESET_PC;
          if (run) state <= EXEC;
        end
        EXEC: begin
          if (stall) begin
            if (!run) begin
              state <= IDLE;
              pc    <= RESET_PC;
            end
          end else begin
            for (int i = 0; i < 6; i++) begin
              if (wr_en && (wr_idx == 3'(i))) regs[i] <= wr_val;
            end
            // An output copy always finishes its handshake before honouring run=0.
            if (to_out) begin
              out_data  <= src_val;
              out_valid <= 1'b1;
              state     <= OUT_WAIT;
            end else if (!run) begin
              state <= IDLE;
              pc    <= RESET_PC;
            end else begin
              pc <= pc_next;
            end
          end
        end
        OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (run) begin
              state <= EXEC;
              pc    <= pc + 8'd1;
            end else begin
              state <= IDLE;
              pc    <= RESET_PC;
            end
          end
        end
        default: begin
          state <= IDLE;
          pc    <= RESET_PC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_overture_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_overture_sequencer                                                |
// | Directed bench: counting, backpressure, ALU/jump, input, reset, run. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_overture_sequencer;

  logic       clk;
  logic       reset_n;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       run;
  logic       busy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  logic [7:0] rom [256];
  logic       alu_mode;
  logic [7:0] in_byte;
  int         checks;
  int         errors;
  int         n;

  overture_sequencer #(.RESET_PC(8'h00)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .run      (run),
    .busy     (busy),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready)
  );

  assign rom_data = rom[rom_addr];
  assign in_data  = alu_mode ? ((rom_addr == 8'h00) ? 8'hF0 : 8'h20) : in_byte;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until out_valid is seen; cnt is the number of edges taken.
  task automatic wait_out(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!out_valid && cnt < 400);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
  endtask

  task automatic load_count();
    fill_nop();
    rom[0] = 8'h00;
    for (int k = 0; k < 10; k++) begin
      rom[1 + 2 * k] = 8'h30 + 8'(k);
      rom[2 + 2 * k] = 8'h86;
    end
    rom[8'h15] = 8'h00;
    rom[8'h16] = 8'hC4;
  endtask

  task automatic load_alu();
    fill_nop();
    rom[0]     = 8'hB1;
    rom[1]     = 8'hB2;
    rom[2]     = 8'h44;
    rom[3]     = 8'h9E;
    rom[4]     = 8'h45;
    rom[5]     = 8'h9E;
    rom[6]     = 8'h41;
    rom[7]     = 8'h9E;
    rom[8]     = 8'h45;
    rom[9]     = 8'h20;
    rom[10]    = 8'hC2;
    rom[11]    = 8'h3F;
    rom[12]    = 8'h86;
    rom[8'h20] = 8'h15;
    rom[8'h21] = 8'h86;
    rom[8'h22] = 8'h44;
    rom[8'h23] = 8'h30;
    rom[8'h24] = 8'hC2;
    rom[8'h25] = 8'h2A;
    rom[8'h26] = 8'h86;
    rom[8'h27] = 8'h27;
    rom[8'h28] = 8'hC4;
    rom[8'h30] = 8'h3F;
    rom[8'h31] = 8'h86;
  endtask

  task automatic restart();
    run      = 1'b0;
    reset_n  = 1'b0;
    tick();
    reset_n  = 1'b1;
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    run       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    alu_mode  = 1'b0;
    load_count();
    tick();

    check("rst_addr", rom_addr, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_oval", out_valid, 1'b0);
    check("rst_odata", out_data, 8'h00);
    check("rst_irdy", in_ready, 1'b0);

    // Counting program with free-flowing output.
    reset_n = 1'b1;
    tick();
    check("idle_busy", busy, 1'b0);
    run = 1'b1;
    wait_out(n);
    check("first_lat", 16'(n), 16'd4);
    check("first_byte", out_data, 8'h30);
    for (int k = 1; k < 10; k++) begin
      wait_out(n);
      check("byte_gap", 16'(n), 16'd3);
      check("byte_val", out_data, 8'h30 + 8'(k));
    end
    wait_out(n);
    check("wrap_gap", 16'(n), 16'd6);
    check("wrap_byte", out_data, 8'h30);

    // Backpressure on the first byte.
    load_count();
    restart();
    out_ready = 1'b0;
    run       = 1'b1;
    wait_out(n);
    check("bp_first", out_data, 8'h30);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", {out_valid, out_data, rom_addr[6:0]}, {1'b1, 8'h30, 7'h02});
    end
    out_ready = 1'b1;
    wait_out(n);
    check("bp_gap", 16'(n), 16'd3);
    check("bp_next", out_data, 8'h31);

    // ALU results and conditional jumps.
    run = 1'b0;
    load_alu();
    restart();
    alu_mode = 1'b1;
    in_valid = 1'b1;
    run      = 1'b1;
    wait_out(n);
    check("alu_add", out_data, 8'h10);
    wait_out(n);
    check("alu_sub", out_data, 8'hD0);
    wait_out(n);
    check("alu_nand", out_data, 8'hDF);
    wait_out(n);
    check("jmp_taken", out_data, 8'h15);
    wait_out(n);
    check("jmp_nottaken", out_data, 8'h2A);
    alu_mode = 1'b0;
    in_valid = 1'b0;

    // Input stall then transfer straight to the output port.
    run = 1'b0;
    fill_nop();
    rom[0] = 8'hB6;
    restart();
    out_ready = 1'b0;
    run       = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("in_stall", {in_ready, rom_addr, out_valid}, {1'b1, 8'h00, 1'b0});
      tick();
    end
    in_byte  = 8'hA5;
    in_valid = 1'b1;
    check("in_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("in_out", {out_valid, out_data, in_ready}, {1'b1, 8'hA5, 1'b0});
    out_ready = 1'b1;

    // Asynchronous reset while an output byte is pending.
    run = 1'b0;
    load_count();
    restart();
    out_ready = 1'b0;
    run       = 1'b1;
    wait_out(n);
    check("pre_rst_oval", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_clear", {out_valid, busy, rom_addr, out_data}, {1'b0, 1'b0, 8'h00, 8'h00});
    @(negedge clk);
    reset_n = 1'b1;
    wait_out(n);
    check("rst_relat", 16'(n), 16'd4);
    check("rst_rebyte", out_data, 8'h30);
    out_ready = 1'b1;

    // run=0 mid-program returns to idle at RESET_PC.
    run = 1'b0;
    restart();
    run = 1'b1;
    tick();
    tick();
    check("stop_pc", rom_addr, 8'h01);
    run = 1'b0;
    tick();
    check("stop_idle", {busy, rom_addr}, {1'b0, 8'h00});
    tick();
    check("stop_hold", {busy, rom_addr}, {1'b0, 8'h00});

    // PC wraps from 0xFF to 0x00 on a NOP image.
    fill_nop();
    restart();
    run = 1'b1;
    n   = 0;
    while (rom_addr != 8'hFF && n < 400) begin
      tick();
      n++;
    end
    check("pc_ff", rom_addr, 8'hFF);
    tick();
    check("pc_wrap", {busy, rom_addr}, {1'b1, 8'h00});
    run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
